// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Holds the default datapath width, the NOP used when decode has nothing
// to consume, and the packet layout that travels from fetch to decode.
package fetch_pkg;

    // Default width of the instruction, PC and PC+4 fields.
    localparam int DATA_WIDTH_DEFAULT = 32;

    // RV32I canonical NOP (addi x0, x0, 0).
    // Decode sees this whenever the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetched packet at the default datapath width.
    // Field order matches the order in which the queue packs its storage word.
    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0] instr;
        logic [DATA_WIDTH_DEFAULT-1:0] pc;
        logic [DATA_WIDTH_DEFAULT-1:0] pc_plus4;
    } fetch_packet_t;

    // Builds a packet from its PC.
    // pc_plus4 is always derived from pc so the two fields can never disagree.
    function automatic fetch_packet_t make_packet(
        input logic [DATA_WIDTH_DEFAULT-1:0] instr,
        input logic [DATA_WIDTH_DEFAULT-1:0] pc
    );
        fetch_packet_t p;
        p.instr    = instr;
        p.pc       = pc;
        p.pc_plus4 = pc + DATA_WIDTH_DEFAULT'(4);
        return p;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, wrapping read/write
// pointers and an explicit occupancy count.
// Full and empty are decoded from the count rather than from comparing
// pointers, so the pointers can simply roll over.
// The flush input clears all occupancy in a single cycle.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic do_push;
    logic do_pop;
    logic mem_we;

    // Occupancy flags come only from the registered count.
    // This keeps them free of any combinational path from push_i or pop_i.
    always_comb begin
        full_o  = (count_q == (AW+1)'(DEPTH));
        empty_o = (count_q == '0);
    end

    // Qualify the requests so an overflow or underflow can never corrupt
    // the pointers, even if the wrapper asks for one.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        mem_we  = do_push && !flush_i && !rst;
    end

    // Next-state pointers and count.
    // A flush overrides both push and pop. A simultaneous push and pop
    // advances both pointers and leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    // The synchronous reset takes priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    // It has no reset because its contents are never observed while the
    // count says the slot is empty.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Show-ahead read of the oldest entry.
    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode.
// Each fetched packet {instr, PC, PC+4} is packed into a sync_fifo word.
// The oldest packet is presented to decode in show-ahead form, with a NOP
// substituted when the queue is empty.
// StallF back-pressures fetch when the queue is full, and FlushD empties
// the queue on a taken branch or jump.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter  int DEPTH      = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidF,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    input  logic                  ReadyD,
    input  logic                  FlushD,
    output logic                  StallF,
    output logic                  ValidD,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic [ADDR_WIDTH:0]   Count
);

    // Packet layout at the configured width. It mirrors fetch_packet_t,
    // which describes the same layout at the default width.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
    } packet_t;

    packet_t wr_pkt;
    packet_t rd_pkt;

    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // Pack the incoming fetch packet.
    // Handshakes depend only on the registered flags, so ValidF and ReadyD
    // never reach an output combinationally.
    always_comb begin
        wr_pkt.instr    = InstrF;
        wr_pkt.pc       = PCF;
        wr_pkt.pc_plus4 = PCPlus4F;
        push            = ValidF && !StallF;
        pop             = ReadyD && ValidD;
    end

    sync_fifo #(
        .WIDTH ($bits(packet_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (FlushD),
        .wdata_i (wr_pkt),
        .rdata_o (rd_pkt),
        .count_o (Count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Map the FIFO flags onto the pipeline control signals.
    // When the queue is empty, substitute a NOP with zero PCs so decode never
    // sees stale storage contents.
    always_comb begin
        StallF   = fifo_full;
        ValidD   = !fifo_empty;
        InstrD   = DATA_WIDTH'(NOP_INSTR);
        PCD      = '0;
        PCPlus4D = '0;
        if (!fifo_empty) begin
            InstrD   = rd_pkt.instr;
            PCD      = rd_pkt.pc;
            PCPlus4D = rd_pkt.pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue.
// A fetch model produces a PC stream and re-presents any packet that was
// not accepted. Every packet the queue should accept goes into an ordered
// expected list, and the negedge monitor checks the decode-side outputs
// and the flags against that list.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          ValidF;
   logic [DW-1:0] InstrF;
   logic [DW-1:0] PCF;
   logic [DW-1:0] PCPlus4F;
   logic          ReadyD;
   logic          FlushD;
   logic          StallF;
   logic          ValidD;
   logic [DW-1:0] InstrD;
   logic [DW-1:0] PCD;
   logic [DW-1:0] PCPlus4D;
   logic [AW:0]   Count;

   int errors = 0;
   int checks = 0;
   bit monOn  = 1'b0;

   // Packets accepted by the queue, oldest first.
   fetch_packet_t sbQ[$];

   // The packet fetch is currently offering.
   fetch_packet_t curPkt;

   // Set when curPkt was offered and stalled, so fetch must re-present it.
   bit holding;

   fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .ValidF   (ValidF),
      .InstrF   (InstrF),
      .PCF      (PCF),
      .PCPlus4F (PCPlus4F),
      .ReadyD   (ReadyD),
      .FlushD   (FlushD),
      .StallF   (StallF),
      .ValidD   (ValidD),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .PCPlus4D (PCPlus4D),
      .Count    (Count)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compares the DUT's current outputs with the head of the expected list.
   // If decode will take the head at the coming edge, the entry is retired.
   task automatic checkOutput();
      int n = sbQ.size();
      checkVal("Count",  32'(Count),  32'(n));
      checkVal("ValidD", 32'(ValidD), (n != 0) ? 32'd1 : 32'd0);
      checkVal("StallF", 32'(StallF), (n == DEPTH) ? 32'd1 : 32'd0);
      if (n != 0) begin
         checkVal("InstrD",   InstrD,   sbQ[0].instr);
         checkVal("PCD",      PCD,      sbQ[0].pc);
         checkVal("PCPlus4D", PCPlus4D, sbQ[0].pc_plus4);
         if (ReadyD) begin
            void'(sbQ.pop_front());
         end
      end else begin
         checkVal("InstrD",   InstrD,   NOP_INSTR);
         checkVal("PCD",      PCD,      32'h0);
         checkVal("PCPlus4D", PCPlus4D, 32'h0);
      end
   endtask

   // Sample mid-cycle, once inputs and outputs have settled.
   always @(negedge clk) begin
      if (monOn) begin
         checkOutput();
      end
   end

   // Drives one cycle of stimulus; the arguments are percentage probabilities.
   // After the edge, the expected list is updated from the queue's rules.
   task automatic applyStimulus(input int pValid, input int pReady, input int pFlush, input int pRst);
      bit accept;
      ValidF   = holding ? 1'b1 : ($urandom_range(99) < pValid);
      ReadyD   = ($urandom_range(99) < pReady);
      FlushD   = ($urandom_range(99) < pFlush);
      rst      = ($urandom_range(99) < pRst);
      InstrF   = curPkt.instr;
      PCF      = curPkt.pc;
      PCPlus4F = curPkt.pc_plus4;
      accept   = ValidF && !rst && !FlushD && (sbQ.size() != DEPTH);
      @(posedge clk);
      #2;
      if (rst || FlushD) begin
         sbQ.delete();
         holding = 1'b0;
         curPkt  = make_packet($urandom, $urandom & 32'hFFFF_FFFC);
      end else if (accept) begin
         sbQ.push_back(curPkt);
         holding = 1'b0;
         curPkt  = make_packet($urandom, curPkt.pc + 32'd4);
      end else if (ValidF) begin
         holding = 1'b1;
      end
   endtask

   // Safety net in case the simulation stops making progress.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios first, then long random mixes.
   initial begin
      rst      = 1'b1;
      ValidF   = 1'b0;
      ReadyD   = 1'b0;
      FlushD   = 1'b0;
      curPkt   = make_packet($urandom, 32'h0);
      holding  = 1'b0;
      InstrF   = curPkt.instr;
      PCF      = curPkt.pc;
      PCPlus4F = curPkt.pc_plus4;
      @(posedge clk);
      #2;
      monOn = 1'b1;
      @(posedge clk);
      #2;

      // Push PCs 0x00, 0x04 and 0x08, then drain them in order.
      repeat (3) applyStimulus(100, 0, 0, 0);
      repeat (5) applyStimulus(0, 100, 0, 0);

      // Fill past full so fetch stalls, open decode for one cycle, then drain.
      repeat (6) applyStimulus(100, 0, 0, 0);
      applyStimulus(100, 100, 0, 0);
      repeat (2) applyStimulus(100, 0, 0, 0);
      repeat (6) applyStimulus(0, 100, 0, 0);

      // Reach a count of 2, then stream push+pop so the pointers wrap.
      repeat (2) applyStimulus(100, 0, 0, 0);
      repeat (10) applyStimulus(100, 100, 0, 0);

      // Reach a count of 3, then flush with a push and a pop in the same cycle.
      applyStimulus(100, 0, 0, 0);
      applyStimulus(100, 100, 100, 0);
      repeat (2) applyStimulus(0, 0, 0, 0);

      // Fill to 4, reset, then push one packet.
      repeat (4) applyStimulus(100, 0, 0, 0);
      applyStimulus(0, 0, 0, 100);
      applyStimulus(100, 0, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 0);

      // Random traffic: balanced, then biased towards staying full.
      repeat (3000) applyStimulus(60, 50, 3, 1);
      repeat (2000) applyStimulus(85, 30, 2, 0);
      repeat (2) applyStimulus(0, 0, 0, 0);

      monOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
